// File: rtl/fir_shift_agc.sv
// Automatic gain control for the FIR output scaler: measures the windowed peak |x| of the
// snooped AXIS stream and picks a shift so the result fits OUT_BITS (fast attack, slow decay).
module fir_shift_agc #(
  parameter int DATA_WIDTH   = 32,
  parameter int WINDOW_LOG2  = 10,
  parameter int SCALER       = 12,
  parameter int OUT_BITS     = 8,
  parameter int HOLD_WINDOWS = 4
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_areset,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  input  logic [DATA_WIDTH-1:0] mon_tdata,
  input  logic                  enable,
  input  logic [3:0]            manual_shift,
  output logic [3:0]            shift,
  output logic                  shift_update,
  output logic [DATA_WIDTH-1:0] peak,
  output logic [15:0]           clip_count
);

  localparam int CLIP_BASE = OUT_BITS - 1 + SCALER;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ACQ, DECIDE, APPLY} state_t;

  state_t                 state;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [DATA_WIDTH-1:0]  acc;
  logic [3:0]             low_cnt;
  logic [3:0]             target;

  logic                   beat, win_done, clip, stalled;
  logic [DATA_WIDTH-1:0]  abs_x, acc_max;
  logic [7:0]             clip_sh;
  int                     msb, req_i;
  logic [3:0]             req;

  assign beat     = mon_tvalid & mon_tready;
  assign stalled  = mon_tvalid & ~mon_tready;
  assign win_done = beat & (&win_cnt);

  always_comb begin
    abs_x = mon_tdata;
    if (mon_tdata[DATA_WIDTH-1])
      abs_x = (mon_tdata == MIN_NEG) ? MAX_POS : (~mon_tdata + 1'b1);
  end

  assign acc_max = (abs_x > acc) ? abs_x : acc;

  // A right shift past the data width yields zero, so large thresholds never clip.
  assign clip_sh = 8'(CLIP_BASE) + {4'd0, shift};
  assign clip    = |(abs_x >> clip_sh);

  always_comb begin
    msb = -1;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (peak[i]) msb = i;
    req_i = msb + 1 - CLIP_BASE;
    if (req_i < 0)       req = 4'd0;
    else if (req_i > 15) req = 4'd15;
    else                 req = 4'(req_i);
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state        <= IDLE;
      shift        <= 4'd0;
      shift_update <= 1'b0;
      peak         <= '0;
      clip_count   <= 16'd0;
      win_cnt      <= '0;
      acc          <= '0;
      low_cnt      <= 4'd0;
      target       <= 4'd0;
    end else begin
      shift_update <= 1'b0;
      if (beat && clip && clip_count != 16'hFFFF)
        clip_count <= clip_count + 16'd1;

      if (!enable || state == IDLE) begin
        win_cnt <= '0;
        acc     <= '0;
        low_cnt <= 4'd0;
        if (state == IDLE) shift <= manual_shift;
        state <= enable ? ACQ : IDLE;
      end else begin
        // Measurement never pauses; windows finishing outside ACQ are simply dropped.
        if (beat) begin
          win_cnt <= win_cnt + 1'b1;
          acc     <= win_done ? '0 : acc_max;
        end
        case (state)
          ACQ: begin
            if (win_done) begin
              peak  <= acc_max;
              state <= DECIDE;
            end
          end
          DECIDE: begin
            if (req > shift) begin
              target  <= req;
              low_cnt <= 4'd0;
            end else if (req < shift) begin
              if (5'(low_cnt) + 5'd1 >= 5'(HOLD_WINDOWS)) begin
                target  <= shift - 4'd1;
                low_cnt <= 4'd0;
              end else begin
                target  <= shift;
                low_cnt <= low_cnt + 4'd1;
              end
            end else begin
              target  <= shift;
              low_cnt <= 4'd0;
            end
            state <= APPLY;
          end
          APPLY: begin
            // Changing shift under a stalled beat would alter data the slave hasn't taken.
            if (!stalled) begin
              shift        <= target;
              shift_update <= (target != shift);
              state        <= ACQ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_shift_agc.sv
// Directed bench for fir_shift_agc: manual mode, attack, full-scale, decay, stall and clip.
module tb_fir_shift_agc;

  logic        clk = 1'b0;
  logic        areset;
  logic        mon_tvalid, mon_tready;
  logic [31:0] mon_tdata;
  logic        enable;
  logic [3:0]  manual_shift;
  logic [3:0]  shift;
  logic        shift_update;
  logic [31:0] peak;
  logic [15:0] clip_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_shift_agc dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(areset),
    .mon_tvalid     (mon_tvalid),
    .mon_tready     (mon_tready),
    .mon_tdata      (mon_tdata),
    .enable         (enable),
    .manual_shift   (manual_shift),
    .shift          (shift),
    .shift_update   (shift_update),
    .peak           (peak),
    .clip_count     (clip_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [31:0] d);
    mon_tvalid = v;
    mon_tready = r;
    mon_tdata  = d;
    step();
  endtask

  task automatic idle_count(input int n, output int p);
    p = 0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (shift_update) p++;
      step();
    end
  endtask

  task automatic test_reset();
    areset = 1'b1; enable = 1'b1; manual_shift = 4'd7;
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tdata = 32'hFFFF_FFFF;
    step(); step();
    @(negedge clk);
    total++;
    if (shift !== 4'd0 || shift_update !== 1'b0 || peak !== 32'd0 || clip_count !== 16'd0) begin
      bad++;
      $display("FAIL reset: shift=%0d upd=%0b peak=%h clip=%0d, want 0/0/0/0",
               shift, shift_update, peak, clip_count);
    end
    areset = 1'b0; enable = 1'b0; manual_shift = 4'd0; mon_tvalid = 1'b0;
    step();
  endtask

  task automatic test_manual();
    manual_shift = 4'd5;
    @(negedge clk);
    total++;
    if (shift !== 4'd0) begin
      bad++; $display("FAIL manual_latency: shift=%0d want 0", shift);
    end
    step();
    @(negedge clk);
    total++;
    if (shift !== 4'd5 || shift_update !== 1'b0) begin
      bad++; $display("FAIL manual_follow: shift=%0d upd=%0b want 5/0", shift, shift_update);
    end
  endtask

  task automatic test_attack();
    int p;
    manual_shift = 4'd0; enable = 1'b1;
    step();
    repeat (1024) drive(1'b1, 1'b1, 32'h0010_0000);
    idle_count(6, p);
    total++;
    if (peak !== 32'h0010_0000 || shift !== 4'd2 || p != 1) begin
      bad++; $display("FAIL attack: peak=%h shift=%0d pulses=%0d want 00100000/2/1", peak, shift, p);
    end
  endtask

  task automatic test_full_scale();
    int p;
    drive(1'b1, 1'b1, 32'h8000_0000);
    repeat (1023) drive(1'b1, 1'b1, 32'h0);
    idle_count(6, p);
    total++;
    if (peak !== 32'h7FFF_FFFF || shift !== 4'd12 || p != 1) begin
      bad++; $display("FAIL full_scale: peak=%h shift=%0d pulses=%0d want 7fffffff/12/1", peak, shift, p);
    end
  endtask

  task automatic test_decay();
    int p;
    logic [3:0] exp_sh;
    enable = 1'b0; manual_shift = 4'd2;
    step(); step();
    enable = 1'b1;
    step();
    @(negedge clk);
    total++;
    if (shift !== 4'd2) begin
      bad++; $display("FAIL decay_seed: shift=%0d want 2", shift);
    end
    for (int w = 1; w <= 8; w++) begin
      repeat (1024) drive(1'b1, 1'b1, 32'h0000_0100);
      idle_count(6, p);
      exp_sh = (w < 4) ? 4'd2 : (w < 8) ? 4'd1 : 4'd0;
      total++;
      if (shift !== exp_sh || p != ((w == 4 || w == 8) ? 1 : 0)) begin
        bad++; $display("FAIL decay_w%0d: shift=%0d pulses=%0d want %0d/%0d",
                        w, shift, p, exp_sh, (w == 4 || w == 8) ? 1 : 0);
      end
    end
    total++;
    if (peak !== 32'h0000_0100) begin
      bad++; $display("FAIL decay_peak: peak=%h want 00000100", peak);
    end
  endtask

  task automatic test_stall();
    repeat (1024) drive(1'b1, 1'b1, 32'h0010_0000);
    mon_tvalid = 1'b1; mon_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (shift !== 4'd0 || shift_update !== 1'b0) begin
        bad++; $display("FAIL stall_hold_c%0d: shift=%0d upd=%0b want 0/0", c, shift, shift_update);
      end
      step();
    end
    mon_tready = 1'b1;
    @(negedge clk);
    total++;
    if (shift !== 4'd0) begin
      bad++; $display("FAIL stall_last: shift=%0d want 0", shift);
    end
    step();
    mon_tvalid = 1'b0;
    @(negedge clk);
    total++;
    if (shift !== 4'd2 || shift_update !== 1'b1) begin
      bad++; $display("FAIL stall_release: shift=%0d upd=%0b want 2/1", shift, shift_update);
    end
    step();
  endtask

  task automatic test_clip();
    int p;
    areset = 1'b1; mon_tvalid = 1'b0;
    step();
    areset = 1'b0; manual_shift = 4'd0; enable = 1'b1;
    step();
    repeat (3) drive(1'b1, 1'b1, 32'h0008_0000);
    drive(1'b1, 1'b1, 32'h0007_FFFF);
    drive(1'b1, 1'b0, 32'h8000_0000);
    drive(1'b1, 1'b1, 32'hFFF8_0000);
    mon_tvalid = 1'b0;
    @(negedge clk);
    total++;
    if (clip_count !== 16'd4) begin
      bad++; $display("FAIL clip_count: got %0d want 4", clip_count);
    end
    manual_shift = 4'd9; enable = 1'b0;
    step();
    @(negedge clk);
    total++;
    if (shift !== 4'd0) begin
      bad++; $display("FAIL disable_first: shift=%0d want 0", shift);
    end
    idle_count(2, p);
    @(negedge clk);
    total++;
    if (shift !== 4'd9 || p != 0 || peak !== 32'd0 || clip_count !== 16'd4) begin
      bad++; $display("FAIL disable_idle: shift=%0d pulses=%0d peak=%h clip=%0d want 9/0/0/4",
                      shift, p, peak, clip_count);
    end
  endtask

  initial begin
    mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tdata = '0;
    enable = 1'b0; manual_shift = 4'd0; areset = 1'b1;
    test_reset();
    test_manual();
    test_attack();
    test_full_scale();
    test_decay();
    test_stall();
    test_clip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
